branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor and branch target buffer (BTB) for the five-stage pipeline; the generalised successor to the static branch-resolution logic.
- IF stage performs a same-cycle lookup on the fetch PC and gets a predicted direction and target.
- EX stage writes back resolved outcomes and receives a registered redirect/flush request on misprediction.
- Table depth, counter width and PC width are parametrised.

Parameters:
- PC_W, 9: fetch PC width in bits, byte address; PC_W >= log2(ENTRIES)+3.
- ENTRIES, 16: number of BTB/BHT entries, direct-mapped; power of two, >= 2.
- CNT_W, 2: saturating direction counter width, >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- fetch_pc  input  PC_W  IF-stage PC for lookup.
- pred_hit  output  1  valid entry with matching tag for fetch_pc.
- pred_taken  output  1  predicted taken.
- pred_target  output  32  predicted target; PC+4 when not predicted taken.
- upd_valid  input  1  EX has a resolved control-flow instruction this cycle.
- upd_pc  input  PC_W  PC of the resolved instruction.
- upd_is_jump  input  1  1 = jal/jalr (unconditional); 0 = conditional branch.
- upd_taken  input  1  actual direction.
- upd_target  input  32  actual target (jalr already LSB-cleared).
- upd_pred_taken  input  1  prediction carried down the pipe with the instruction.
- upd_pred_target  input  32  predicted target carried down the pipe.
- redirect  output  1  registered misprediction flush, one cycle.
- redirect_pc  output  32  correct next PC, valid while redirect = 1.

Behaviour:
- Index = pc[IDX_W+1:2], IDX_W = log2(ENTRIES). Tag = pc[PC_W-1:IDX_W+2], zero-extended to 32 bits for arithmetic.
- Each entry holds: valid, tag, 32-bit target, CNT_W-bit counter, jump flag.
- Lookup is combinational (0-cycle latency):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jump flag | counter MSB).
  - pred_target = stored target if pred_taken, else {zero-ext fetch_pc}+4, wrapping modulo 2^32.
- Update is registered on the rising edge when upd_valid = 1.
  - Hit, conditional branch: counter +1 if taken, saturating at 2^CNT_W-1; -1 if not taken, saturating at 0. If taken, target is overwritten with upd_target.
  - Hit, jump: target overwritten, jump flag = 1, counter forced to all-ones.
  - Miss (invalid entry or tag differs), taken: allocate and replace unconditionally. valid = 1, new tag, target = upd_target, jump flag = upd_is_jump, counter = weakly-taken (MSB=1, rest 0), or all-ones for a jump.
  - Miss, not taken: table unchanged.
- Read-during-write on the same index: lookup returns pre-update contents; the new contents are visible from the next cycle.
- Mispredict condition (combinational from upd_*): upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
- Registered outputs on the next edge:
  - redirect = mispredict condition.
  - redirect_pc = upd_target if upd_taken, else {zero-ext upd_pc}+4.
  - redirect is high for exactly one cycle per mispredicted instruction. Back-to-back mispredicts give back-to-back pulses.
- Reset, synchronous:
  - All valid bits = 0, all counters = weakly-not-taken (MSB=0, rest 1; 0 when CNT_W=1), jump flags = 0.
  - redirect = 0, redirect_pc = 0.
  - Reset asserted in the same cycle as upd_valid: reset wins and the update is dropped.
  - After reset deassertion, the first lookup is a miss: pred_hit = 0, pred_taken = 0, pred_target = PC+4.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_branches [31:0] (count of upd_valid cycles) and stat_mispredicts [31:0] (count of mispredict conditions).
  - Both saturate at 32'hFFFFFFFF and clear on reset.
  - Both update on the same edge as the redirect register.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=0x040 -> pred_hit=0, pred_taken=0, pred_target=0x044; redirect=0.
- Update pc=0x040, branch taken, target=0x080, pred_taken=0 -> next cycle redirect=1, redirect_pc=0x080; lookup 0x040 gives hit=1, taken=1, target=0x080.
- Update pc=0x040 not-taken twice, predicted taken each time -> counter 10->01->00; lookup gives taken=0, target=0x044; two redirect pulses, both with redirect_pc=0x044.
- Counter saturation, CNT_W=2: five taken updates at 0x040 -> counter stays 11; one not-taken update -> still predicts taken.
- Aliasing, ENTRIES=16: entry at 0x040 valid, then taken update at 0x140 (same index, new tag) -> 0x040 misses, 0x140 hits; a not-taken update at 0x1C0 leaves the table unchanged.
- Jump with wrong target: jump at 0x010, pred_target=0x020, actual 0x030 -> redirect=1, redirect_pc=0x030. Same-cycle lookup of 0x010 returns the old target 0x020; the next cycle returns 0x030.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB + saturating-counter BHT with a same-cycle IF lookup and registered EX redirect.
// Ports: clk/reset (sync, active-high); fetch_pc -> pred_hit/pred_taken/pred_target (combinational lookup);
// upd_* from EX (resolved control flow) -> redirect/redirect_pc (registered one-cycle flush request).
// Optional BP_STATS_EN adds stat_branches/stat_mispredicts saturating 32-bit counters.
module branch_predictor #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [31:0]     upd_target,
  input  logic            upd_pred_taken,
  input  logic [31:0]     upd_pred_target,
  output logic            redirect,
  output logic [31:0]     redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [IDX_W-1:0] w_fidx, w_uidx;
  logic [TAG_W-1:0] w_ftag, w_utag;
  logic [CNT_W-1:0] w_ucnt, w_cnt_next;
  logic             w_uhit, w_mis;
  assign w_fidx = fetch_pc[IDX_W+1:2];
  assign w_ftag = fetch_pc[PC_W-1:IDX_W+2];
  assign w_uidx = upd_pc[IDX_W+1:2];
  assign w_utag = upd_pc[PC_W-1:IDX_W+2];
  assign pred_hit    = r_valid[w_fidx] & (r_tag[w_fidx] == w_ftag);
  assign pred_taken  = pred_hit & (r_jump[w_fidx] | r_cnt[w_fidx][CNT_W-1]);
  assign pred_target = pred_taken ? r_target[w_fidx] : 32'(fetch_pc) + 32'd4;
  assign w_uhit = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
  assign w_ucnt = r_cnt[w_uidx];
  assign w_cnt_next = upd_taken ? ((w_ucnt == '1) ? w_ucnt : w_ucnt + CNT_W'(1))
                                : ((w_ucnt == '0) ? w_ucnt : w_ucnt - CNT_W'(1));
  assign w_mis = upd_valid & ((upd_taken != upd_pred_taken) |
                              (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WNT;
        r_jump[i]  <= 1'b0;
      end
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect    <= w_mis;
      redirect_pc <= upd_taken ? upd_target : 32'(upd_pc) + 32'd4;
      if (upd_valid) begin
        if (w_uhit && upd_is_jump) begin
          r_target[w_uidx] <= upd_target;
          r_jump[w_uidx]   <= 1'b1;
          r_cnt[w_uidx]    <= '1;
        end else if (w_uhit) begin
          r_cnt[w_uidx] <= w_cnt_next;
          if (upd_taken) r_target[w_uidx] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_uidx]  <= 1'b1;
          r_tag[w_uidx]    <= w_utag;
          r_target[w_uidx] <= upd_target;
          r_jump[w_uidx]   <= upd_is_jump;
          r_cnt[w_uidx]    <= upd_is_jump ? '1 : CNT_WT;
        end
      end
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (w_mis && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table vectors, reset corner case and randomized checks against a behavioural model.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [8:0]  upd_pc;
  logic        upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_target, upd_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif
  int total = 0;
  int bad = 0;

  branch_predictor #(.PC_W(9), .ENTRIES(16), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit uv; logic [8:0] upc; bit uj; bit ut; logic [31:0] utg; bit upt; logic [31:0] uptg;
    logic [8:0] fpc; bit eh; bit et; logic [31:0] etg; bit er; logic [31:0] erpc;
  } vec_t;
  vec_t vecs[22];

  int m_valid[16], m_tag[16], m_cnt[16], m_jmp[16];
  int unsigned m_tgt[16];

  task automatic drive(input bit uv, input logic [8:0] upc, input bit uj, input bit ut,
                       input logic [31:0] utg, input bit upt, input logic [31:0] uptg, input logic [8:0] fpc);
    upd_valid = uv; upd_pc = upc; upd_is_jump = uj; upd_taken = ut;
    upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg; fetch_pc = fpc;
  endtask

  function automatic void m_lookup(input int pc, output bit h, output bit t, output int unsigned tg);
    int idx = (pc / 4) % 16;
    h = m_valid[idx] != 0 && m_tag[idx] == pc / 64;
    t = h && (m_jmp[idx] != 0 || m_cnt[idx] >= 2);
    tg = t ? m_tgt[idx] : pc + 4;
  endfunction

  function automatic void m_update(input int pc, input bit j, input bit t, input int unsigned tg);
    int idx = (pc / 4) % 16;
    bit h = m_valid[idx] != 0 && m_tag[idx] == pc / 64;
    if (h && j) begin
      m_tgt[idx] = tg; m_jmp[idx] = 1; m_cnt[idx] = 3;
    end else if (h) begin
      m_cnt[idx] = t ? (m_cnt[idx] < 3 ? m_cnt[idx] + 1 : 3) : (m_cnt[idx] > 0 ? m_cnt[idx] - 1 : 0);
      if (t) m_tgt[idx] = tg;
    end else if (t) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tg; m_jmp[idx] = j; m_cnt[idx] = j ? 3 : 2;
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_cnt[i] = 1; m_jmp[i] = 0; m_tgt[i] = 0;
    end
  endtask

  initial begin
    vecs[0]  = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h040, 0, 0, 32'h044, 0, 32'h0};
    vecs[1]  = '{1, 9'h040, 0, 1, 32'h080, 0, 32'h0,   9'h040, 0, 0, 32'h044, 1, 32'h080};
    vecs[2]  = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h040, 1, 1, 32'h080, 0, 32'h0};
    vecs[3]  = '{1, 9'h040, 0, 0, 32'h0,   1, 32'h080, 9'h040, 1, 1, 32'h080, 1, 32'h044};
    vecs[4]  = '{1, 9'h040, 0, 0, 32'h0,   1, 32'h080, 9'h040, 1, 0, 32'h044, 1, 32'h044};
    vecs[5]  = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h040, 1, 0, 32'h044, 0, 32'h0};
    vecs[6]  = '{1, 9'h040, 0, 1, 32'h080, 1, 32'h080, 9'h040, 1, 0, 32'h044, 0, 32'h0};
    vecs[7]  = '{1, 9'h040, 0, 1, 32'h080, 1, 32'h080, 9'h040, 1, 0, 32'h044, 0, 32'h0};
    vecs[8]  = '{1, 9'h040, 0, 1, 32'h080, 1, 32'h080, 9'h040, 1, 1, 32'h080, 0, 32'h0};
    vecs[9]  = '{1, 9'h040, 0, 1, 32'h080, 1, 32'h080, 9'h040, 1, 1, 32'h080, 0, 32'h0};
    vecs[10] = '{1, 9'h040, 0, 1, 32'h080, 1, 32'h080, 9'h040, 1, 1, 32'h080, 0, 32'h0};
    vecs[11] = '{1, 9'h040, 0, 0, 32'h0,   1, 32'h080, 9'h040, 1, 1, 32'h080, 1, 32'h044};
    vecs[12] = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h040, 1, 1, 32'h080, 0, 32'h0};
    vecs[13] = '{1, 9'h140, 0, 1, 32'h100, 0, 32'h0,   9'h140, 0, 0, 32'h144, 1, 32'h100};
    vecs[14] = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h040, 0, 0, 32'h044, 0, 32'h0};
    vecs[15] = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h140, 1, 1, 32'h100, 0, 32'h0};
    vecs[16] = '{1, 9'h1C0, 0, 0, 32'h0,   0, 32'h0,   9'h140, 1, 1, 32'h100, 0, 32'h0};
    vecs[17] = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h140, 1, 1, 32'h100, 0, 32'h0};
    vecs[18] = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h1C0, 0, 0, 32'h1C4, 0, 32'h0};
    vecs[19] = '{1, 9'h010, 1, 1, 32'h020, 0, 32'h0,   9'h010, 0, 0, 32'h014, 1, 32'h020};
    vecs[20] = '{1, 9'h010, 1, 1, 32'h030, 1, 32'h020, 9'h010, 1, 1, 32'h020, 1, 32'h030};
    vecs[21] = '{0, 9'h000, 0, 0, 32'h0,   0, 32'h0,   9'h010, 1, 1, 32'h030, 0, 32'h0};

    do_reset();
    chk("reset_redirect", 32'(redirect), 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].uv, vecs[i].upc, vecs[i].uj, vecs[i].ut, vecs[i].utg, vecs[i].upt, vecs[i].uptg, vecs[i].fpc);
      #3;
      chk($sformatf("vec%0d_hit", i), 32'(pred_hit), 32'(vecs[i].eh));
      chk($sformatf("vec%0d_taken", i), 32'(pred_taken), 32'(vecs[i].et));
      chk($sformatf("vec%0d_target", i), pred_target, vecs[i].etg);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_redirect", i), 32'(redirect), 32'(vecs[i].er));
      if (vecs[i].er) chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].erpc);
    end

    reset = 1'b1;
    drive(1, 9'h080, 0, 1, 32'h200, 0, 32'h0, 9'h080);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 9'h080);
    chk("rst_upd_redirect", 32'(redirect), 32'd0);
    chk("rst_upd_redirect_pc", redirect_pc, 32'd0);
    #1;
    chk("rst_upd_hit", 32'(pred_hit), 32'd0);
    chk("rst_upd_target", pred_target, 32'h084);
    fetch_pc = 9'h010;
    #1;
    chk("rst_clears_010", 32'(pred_hit), 32'd0);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      int pc, fpc;
      bit uv, uj, ut, upt, eh, et, er;
      int unsigned utg, uptg, etg, erpc, mtg;
      int unsigned tset[4] = '{32'h100, 32'h200, 32'h3FC, 32'h0};
      pc  = $urandom_range(0, 2) * 64 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
      fpc = ($urandom_range(0, 3) == 0) ? pc : $urandom_range(0, 2) * 64 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
      uv = $urandom_range(0, 3) != 0;
      uj = $urandom_range(0, 4) == 0;
      ut = uj ? 1'b1 : 1'($urandom_range(0, 1));
      tset[3] = $urandom & 32'hFFFF_FFFC;
      utg = tset[$urandom_range(0, 3)];
      m_lookup(pc, eh, upt, mtg);
      uptg = mtg;
      if ($urandom_range(0, 2) == 0) begin
        upt = 1'($urandom_range(0, 1));
        uptg = tset[$urandom_range(0, 3)];
      end
      drive(uv, 9'(pc), uj, ut, utg, upt, uptg, 9'(fpc));
      #3;
      m_lookup(fpc, eh, et, etg);
      chk("rand_hit", 32'(pred_hit), 32'(eh));
      chk("rand_taken", 32'(pred_taken), 32'(et));
      chk("rand_target", pred_target, etg);
      er = uv && ((ut != upt) || (ut && upt && utg != uptg));
      erpc = ut ? utg : pc + 4;
      @(posedge clk);
      #1;
      if (uv) m_update(pc, uj, ut, utg);
      chk("rand_redirect", 32'(redirect), 32'(er));
      if (er) chk("rand_redirect_pc", redirect_pc, erpc);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
